// File: rtl/result_drain_if.sv
// result_drain_if: valid/ready result stream from the drain buffer to a host or trace port.
interface result_drain_if #(parameter int N = 8) ();
  logic [N-1:0] data_o;
  logic         valid_o;
  logic         ready_i;
  modport master (output data_o, valid_o, input ready_i);
  modport slave  (input data_o, valid_o, output ready_i);
endinterface

// File: rtl/result_drain.sv
// result_drain: buffers core results captured on register-file writes and drains them after halt.
// Optional RESULT_DEDUP_EN suppresses captures equal to the last pushed value.
module result_drain #(
  parameter int N     = 8,
  parameter int DEPTH = 16,
  parameter int W_CNT = 16
) (
  input  logic                     clk_i,
  input  logic                     n_rst_i,
  input  logic                     cap_en_i,
  input  logic [N-1:0]             result_i,
  input  logic                     halt_i,
  result_drain_if.master           out_if,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [W_CNT-1:0]         drop_cnt_o,
  output logic                     done_o
);
  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] cnt_t;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  state_t        state_q, state_d;
  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q;
  cnt_t          cnt_q, cnt_d;
  logic [N-1:0]  data_q, data_d;
  logic          valid_q, valid_d, done_q;
  logic [W_CNT-1:0] drop_q;
  logic          full, pop, dup, cap, push, drop;
`ifdef RESULT_DEDUP_EN
  logic [N-1:0]  last_q;
  logic          last_v_q;
  assign dup = last_v_q && result_i == last_q;
  always_ff @(posedge clk_i) begin
    if (!n_rst_i) begin
      last_q   <= '0;
      last_v_q <= 1'b0;
    end else if (push) begin
      last_q   <= result_i;
      last_v_q <= 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif
  assign full = cnt_q == cnt_t'(DEPTH);
  assign pop  = valid_q && out_if.ready_i;
  assign cap  = state_q == RUN && cap_en_i && !dup;
  assign push = cap && (!full || pop);
  assign drop = cap && full && !pop;
  // Next head is the incoming value when the buffer would otherwise be empty.
  always_comb begin
    rd_d    = rd_q + AW'(pop);
    cnt_d   = cnt_q + cnt_t'(push) - cnt_t'(pop);
    valid_d = cnt_d != '0;
    data_d  = !valid_d ? data_q : (cnt_q == cnt_t'(pop)) ? result_i : mem[rd_d];
    state_d = state_q == RUN   ? (halt_i ? DRAIN : RUN) :
              state_q == DRAIN ? ((cnt_q == '0 && !push) ? DONE : DRAIN) : DONE;
  end
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_q] <= result_i;
  end
  always_ff @(posedge clk_i) begin
    if (!n_rst_i) begin
      state_q <= RUN;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      drop_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_q + AW'(push);
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      drop_q  <= drop_q + W_CNT'(drop && !(&drop_q));
      done_q  <= state_d == DONE;
    end
  end
  assign out_if.data_o  = data_q;
  assign out_if.valid_o = valid_q;
  assign count_o        = cnt_q;
  assign drop_cnt_o     = drop_q;
  assign done_o         = done_q;
endmodule
